// File: rtl/ep2_aes_pkg.sv
// Shared AES-path helpers: block size, beat byte counting and 16-byte padding masks.
// Latency: combinational functions only.
// Backpressure: not applicable.
package ep2_aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    // Widest tkeep the helpers support (1024-bit data path); narrower buses zero-extend.
    localparam int MAX_KEEP_W = 128;
    localparam int BCNT_W     = 8;

    typedef logic [MAX_KEEP_W-1:0] keep_max_t;
    typedef logic [BCNT_W-1:0]     bcnt_t;

    // Number of set byte enables in a beat.
    function automatic bcnt_t popcount(input keep_max_t keep);
        bcnt_t c;
        c = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            c = c + bcnt_t'(keep[i]);
        end
        return c;
    endfunction

    // Byte idx of a beat carrying n payload bytes is real payload (not padding).
    function automatic logic byte_mask(input bcnt_t n, input int idx);
        return idx < int'(n);
    endfunction

    // Byte idx is enabled once n is rounded up to a whole number of AES blocks.
    function automatic logic pad_keep(input bcnt_t n, input int idx);
        int blk_bytes;
        blk_bytes = ((int'(n) + AES_BLOCK_BYTES - 1) / AES_BLOCK_BYTES) * AES_BLOCK_BYTES;
        return idx < blk_bytes;
    endfunction

endpackage

// File: rtl/axis_fifo.sv
// Generic single-clock AXI-Stream FIFO for narrow sideband words.
// Latency: a pushed word is visible on the output one cycle after it is written.
// Backpressure: s_axis_tready drops when full; push and pop in one cycle keep occupancy.
module axis_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    assign s_axis_tready = (r_count != CNT_W'(DEPTH));
    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_pop         = m_axis_tvalid && m_axis_tready;

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/aes_block_padder.sv
// Pads each frame's last beat to whole 16-byte AES blocks and reports the original frame length.
// Latency: data 1 cycle (single output register); length word 1 cycle via the metadata FIFO.
// Backpressure: input stalls when the output register is held or the length FIFO is full.
module aes_block_padder
    import ep2_aes_pkg::*;
#(
    parameter int DATA_WIDTH     = 512,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int LEN_WIDTH      = 16,
    parameter int LEN_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [LEN_WIDTH-1:0]  m_len_tdata,
    output logic                  m_len_tuser,
    output logic                  m_len_tvalid,
    input  logic                  m_len_tready
);

    // Sum is wide enough to hold a saturated count plus one full beat without wrapping.
    localparam int SUM_W = LEN_WIDTH + BCNT_W;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    typedef struct packed {
        logic                 sat;
        logic [LEN_WIDTH-1:0] len;
    } len_meta_t;

    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_sat;

    bcnt_t                 w_n;
    logic                  w_s_fire;
    logic                  w_fwd;
    logic                  w_fifo_rdy;
    logic                  w_push;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_ovf;
    logic [LEN_WIDTH-1:0]  w_cnt_next;
    logic                  w_sat_next;
    logic [DATA_WIDTH-1:0] w_pad_data;
    logic [KEEP_WIDTH-1:0] w_pad_keep;
    len_meta_t             w_meta_in;
    len_meta_t             w_meta_out;

    assign w_n = popcount(keep_max_t'(s_axis_tkeep));

    // Metadata space is required on every beat so a frame is never split by a length stall.
    assign s_axis_tready = (!m_axis_tvalid || m_axis_tready) && w_fifo_rdy;
    assign w_s_fire      = s_axis_tvalid && s_axis_tready;

    // Empty non-last beats carry nothing and are swallowed; an empty last beat still closes the frame.
    assign w_fwd  = s_axis_tlast || (s_axis_tkeep != '0);
    assign w_push = w_s_fire && s_axis_tlast;

    // Byte count of the frame including the current beat, clamped at the counter maximum.
    assign w_sum      = SUM_W'(r_cnt) + SUM_W'(w_n);
    assign w_ovf      = (w_sum[SUM_W-1:LEN_WIDTH] != '0);
    assign w_cnt_next = w_ovf ? LEN_MAX : w_sum[LEN_WIDTH-1:0];
    assign w_sat_next = r_sat || w_ovf;

    assign w_meta_in  = '{sat: w_sat_next, len: w_cnt_next};

    // Last beat: zero bytes past the payload and widen tkeep to whole AES blocks; other beats pass through.
    always_comb begin
        w_pad_data = s_axis_tdata;
        w_pad_keep = s_axis_tkeep;
        if (s_axis_tlast) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                if (!byte_mask(w_n, i)) begin
                    w_pad_data[8*i +: 8] = 8'h00;
                end
                w_pad_keep[i] = pad_keep(w_n, i);
            end
        end
    end

    // Single output register: load on an accepted forwarded beat, otherwise drain when taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (w_s_fire && w_fwd) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_pad_data;
            m_axis_tkeep  <= w_pad_keep;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Running frame byte count with sticky saturation; cleared as the last beat's total is queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_s_fire) begin
            if (s_axis_tlast) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else begin
                r_cnt <= w_cnt_next;
                r_sat <= w_sat_next;
            end
        end
    end

    axis_fifo #(
        .DATA_WIDTH (LEN_WIDTH + 1),
        .DEPTH      (LEN_FIFO_DEPTH)
    ) u_len_fifo (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (w_meta_in),
        .s_axis_tvalid (w_push),
        .s_axis_tready (w_fifo_rdy),
        .m_axis_tdata  (w_meta_out),
        .m_axis_tvalid (m_len_tvalid),
        .m_axis_tready (m_len_tready)
    );

    assign m_len_tdata = w_meta_out.len;
    assign m_len_tuser = w_meta_out.sat;

endmodule

// File: tb/tb_aes_block_padder.sv
// Self-checking bench for aes_block_padder with a byte-level reference model.
// Latency: checks 1-cycle data and metadata visibility after acceptance.
// Backpressure: exercises random output stalls, metadata FIFO full and mid-frame reset.
module tb_aes_block_padder;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int LW = 8;
    localparam int FD = 8;
    localparam int LMAX = (1 << LW) - 1;

    typedef logic [511:0] w512_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic [KW-1:0] keep;
        logic          last;
    } exp_beat_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [LW-1:0] m_len_tdata;
    logic          m_len_tuser;
    logic          m_len_tvalid;
    logic          m_len_tready;

    exp_beat_t     q_beat[$];
    logic [LW:0]   q_len[$];
    int            frame_bytes;
    int            n_err;
    int            n_chk;
    bit            rnd_rdy;

    logic          prev_hold;
    logic [DW-1:0] hold_dat;
    logic [KW:0]   hold_kl;
    exp_beat_t     mon_e;
    logic [LW:0]   mon_l;
    logic [DW-1:0] d9;

    aes_block_padder #(
        .DATA_WIDTH     (DW),
        .KEEP_WIDTH     (KW),
        .LEN_WIDTH      (LW),
        .LEN_FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_len_tdata   (m_len_tdata),
        .m_len_tuser   (m_len_tuser),
        .m_len_tvalid  (m_len_tvalid),
        .m_len_tready  (m_len_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input w512_t got, input w512_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [KW-1:0] keep_of(input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    // Reference model: what one accepted input beat must produce downstream.
    task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last);
        exp_beat_t e;
        int n;
        int padded;
        n = $countones(k);
        if (last || k != '0) begin
            e.last = last;
            if (!last) begin
                e.data = d;
                e.mask = '1;
                e.keep = k;
            end else begin
                padded = ((n + 15) / 16) * 16;
                e.data = '0;
                e.keep = '0;
                e.mask = '0;
                for (int i = 0; i < KW; i++) begin
                    if (i < n) e.data[8*i +: 8] = d[8*i +: 8];
                    if (i < padded) begin
                        e.keep[i] = 1'b1;
                        e.mask[8*i +: 8] = 8'hFF;
                    end
                end
                if (padded == 0) e.mask = '1;
            end
            q_beat.push_back(e);
        end
        frame_bytes += n;
        if (last) begin
            q_len.push_back({frame_bytes > LMAX, (frame_bytes > LMAX) ? LW'(LMAX) : LW'(frame_bytes)});
            frame_bytes = 0;
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, then record it in the model.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last);
        int w;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!s_axis_tready && w < 2000) begin
            w++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            chk("tready_timeout", 0, 1);
            s_axis_tvalid = 1'b0;
        end else begin
            model_accept(d, k, last);
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        rnd_rdy = 0;
        m_axis_tready = 1'b1;
        m_len_tready  = 1'b1;
        w = 0;
        while ((q_beat.size() != 0 || q_len.size() != 0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", w512_t'(q_beat.size() + q_len.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rnd_rdy       = 0;
        m_axis_tready = 1'b0;
        m_len_tready  = 1'b0;
        s_axis_tvalid = 1'b0;
        rst           = 1'b1;
        q_beat.delete();
        q_len.delete();
        frame_bytes = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mvld", w512_t'(m_axis_tvalid), 0);
        chk("rst_lvld", w512_t'(m_len_tvalid), 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rnd_rdy = 1;
    endtask

    // Random downstream readiness, changed away from the active edge.
    always @(posedge clk) begin
        #1;
        if (rnd_rdy) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            m_len_tready  = ($urandom_range(0, 1) != 0);
        end
    end

    // Output monitor: hold stability, data stream and metadata stream against the model.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_vld", w512_t'(m_axis_tvalid), 1);
                chk("hold_dat", m_axis_tdata, hold_dat);
                chk("hold_kl", w512_t'({m_axis_tkeep, m_axis_tlast}), w512_t'(hold_kl));
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            hold_dat  = m_axis_tdata;
            hold_kl   = {m_axis_tkeep, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready) begin
                if (q_beat.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    mon_e = q_beat.pop_front();
                    chk("data", m_axis_tdata & mon_e.mask, mon_e.data & mon_e.mask);
                    chk("keep", w512_t'(m_axis_tkeep), w512_t'(mon_e.keep));
                    chk("last", w512_t'(m_axis_tlast), w512_t'(mon_e.last));
                end
            end
            if (m_len_tvalid && m_len_tready) begin
                if (q_len.size() == 0) begin
                    chk("extra_len", 1, 0);
                end else begin
                    mon_l = q_len.pop_front();
                    chk("len", w512_t'({m_len_tuser, m_len_tdata}), w512_t'(mon_l));
                end
            end
        end
    end

    initial begin
        int nb;
        int n;
        bit last;
        n_err = 0;
        n_chk = 0;
        rnd_rdy = 0;
        prev_hold = 1'b0;
        frame_bytes = 0;
        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        m_len_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mvld0", w512_t'(m_axis_tvalid), 0);
        chk("rst_lvld0", w512_t'(m_len_tvalid), 0);
        chk("rst_mdat0", m_axis_tdata, 0);
        chk("rst_mkeep0", w512_t'(m_axis_tkeep), 0);
        chk("rst_mlast0", w512_t'(m_axis_tlast), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        m_len_tready  = 1'b1;

        // 5-byte single-beat frame; both streams valid one cycle after acceptance.
        send_beat(rand_data(), keep_of(5), 1'b1);
        @(negedge clk);
        chk("lat_dvld", w512_t'(m_axis_tvalid), 1);
        chk("lat_lvld", w512_t'(m_len_tvalid), 1);
        @(posedge clk);
        #1;

        // 64 + 18 bytes, 64 + 32 bytes, empty-beat handling, saturation and exactly-max length.
        send_beat(rand_data(), keep_of(64), 1'b0);
        send_beat(rand_data(), keep_of(18), 1'b1);
        send_beat(rand_data(), keep_of(64), 1'b0);
        send_beat(rand_data(), keep_of(32), 1'b1);
        send_beat(rand_data(), keep_of(0), 1'b0);
        send_beat(rand_data(), keep_of(4), 1'b0);
        send_beat(rand_data(), keep_of(0), 1'b1);
        for (int b = 0; b < 5; b++) send_beat(rand_data(), keep_of(64), b == 4);
        send_beat(rand_data(), keep_of(64), 1'b0);
        send_beat(rand_data(), keep_of(64), 1'b0);
        send_beat(rand_data(), keep_of(10), 1'b1);
        for (int b = 0; b < 3; b++) send_beat(rand_data(), keep_of(64), 1'b0);
        send_beat(rand_data(), keep_of(63), 1'b1);
        wait_idle();

        // Length FIFO full: eight frames fit, the ninth stalls until metadata drains.
        m_len_tready = 1'b0;
        for (int f = 0; f < FD; f++) send_beat(rand_data(), keep_of($urandom_range(1, 64)), 1'b1);
        d9 = rand_data();
        s_axis_tdata  = d9;
        s_axis_tkeep  = keep_of(33);
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_stall", w512_t'(s_axis_tready), 0);
        chk("full_drain", w512_t'(m_axis_tvalid), 0);
        @(posedge clk);
        #1;
        m_len_tready = 1'b1;
        send_beat(d9, keep_of(33), 1'b1);
        wait_idle();

        // Random frames under random backpressure, with a reset mid-frame.
        rnd_rdy = 1;
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                last = (b == nb - 1);
                if (!last) n = ($urandom_range(0, 3) != 0) ? 64 : $urandom_range(0, 64);
                else n = $urandom_range(0, 64);
                send_beat(rand_data(), keep_of(n), last);
            end
            if (f == 20) begin
                send_beat(rand_data(), keep_of(64), 1'b0);
                send_beat(rand_data(), keep_of(7), 1'b0);
                do_reset();
                send_beat(rand_data(), keep_of(20), 1'b1);
            end
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
